// File: rtl/sram_lsu.sv
// sram_lsu: byte/halfword/word load-store unit in front of the on-chip SRAM.
// Ports:
//   clock, reset          - rising-edge clock, async active-high reset
//   req_*                 - CPU request (valid/ready), latched on accept
//   rsp_valid/rdata/fault - one-cycle response pulse, no backpressure
//   mem_*                 - SRAM read_write/address/data_in/data_out
//   stat_accesses/faults  - saturating counters, only with SRAM_LSU_STATS_EN
// Sub-word stores are done as read-modify-write of the containing word.
module sram_lsu #(
    parameter logic [31:0] SRAM_BASE        = 32'h2000_0000,
    parameter logic [31:0] SRAM_SIZE        = 32'h0001_8000,
    parameter int          MEM_READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_read_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in
`ifdef SRAM_LSU_STATS_EN
    ,
    output logic [15:0] stat_accesses,
    output logic [15:0] stat_faults
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_CAP   = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [1:0] LAT_LAST = 2'(MEM_READ_LATENCY - 1);

    // Window end computed with a carry bit so the bound test cannot wrap.
    localparam logic [32:0] WIN_LAST =
        {1'b0, SRAM_BASE} + {1'b0, SRAM_SIZE} - 33'd1;

    logic [2:0]  state;
    logic        q_write;
    logic [1:0]  q_size;
    logic        q_signed;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic        q_fault;
    logic [31:0] q_word;
    logic [1:0]  rd_cnt;

    logic [32:0] nbytes;
    logic [32:0] last_byte;
    logic        fault;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic [31:0] aligned;

    assign req_ready = (state == S_IDLE);
    assign aligned   = {q_addr[31:2], 2'b00};

    always_comb begin
        nbytes = 33'd4;
        unique case (q_size)
            2'b00:   nbytes = 33'd1;
            2'b01:   nbytes = 33'd2;
            default: nbytes = 33'd4;
        endcase
        last_byte = {1'b0, q_addr} + nbytes - 33'd1;
        fault = (q_addr < SRAM_BASE)
              | (last_byte > WIN_LAST)
              | ((q_size == 2'b01) & q_addr[0])
              | ((q_size == 2'b10) & (q_addr[1:0] != 2'b00))
              | (q_size == 2'b11);
    end

    // Lane extraction for loads and lane merge for RMW stores both work
    // on the word currently returned by the SRAM.
    always_comb begin
        lane_b   = mem_data_in[{q_addr[1:0], 3'b000} +: 8];
        lane_h   = mem_data_in[{q_addr[1], 4'b0000} +: 16];
        load_val = mem_data_in;
        merged   = mem_data_in;
        unique case (q_size)
            2'b00: begin
                load_val = {{24{q_signed & lane_b[7]}}, lane_b};
                merged[{q_addr[1:0], 3'b000} +: 8] = q_wdata[7:0];
            end
            2'b01: begin
                load_val = {{16{q_signed & lane_h[15]}}, lane_h};
                merged[{q_addr[1], 4'b0000} +: 16] = q_wdata[15:0];
            end
            default: begin
                load_val = mem_data_in;
                merged   = q_wdata;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            q_write        <= 1'b0;
            q_size         <= 2'b00;
            q_signed       <= 1'b0;
            q_addr         <= 32'h0;
            q_wdata        <= 32'h0;
            q_fault        <= 1'b0;
            q_word         <= 32'h0;
            rd_cnt         <= 2'd0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'h0;
            rsp_fault      <= 1'b0;
            mem_read_write <= 1'b0;
            mem_address    <= 32'h0;
            mem_data_out   <= 32'h0;
`ifdef SRAM_LSU_STATS_EN
            stat_accesses  <= 16'h0;
            stat_faults    <= 16'h0;
`endif
        end else begin
            rsp_valid      <= 1'b0;
            rsp_fault      <= 1'b0;
            mem_read_write <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        q_write  <= req_write;
                        q_size   <= req_size;
                        q_signed <= req_signed;
                        q_addr   <= req_address;
                        q_wdata  <= req_wdata;
                        q_fault  <= 1'b0;
                        q_word   <= 32'h0;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (fault) begin
                        q_fault <= 1'b1;
                        state   <= S_RESP;
                    end else if (q_write && q_size == 2'b10) begin
                        mem_read_write <= 1'b1;
                        mem_address    <= aligned;
                        mem_data_out   <= q_wdata;
                        state          <= S_WR;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        mem_address <= aligned;
                        rd_cnt      <= 2'd0;
                        state       <= S_RD;
                    end
                end
                S_RD: begin
                    if (rd_cnt == LAT_LAST) begin
                        state <= S_CAP;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                S_CAP: begin
                    if (q_write) begin
                        mem_read_write <= 1'b1;
                        mem_data_out   <= merged;
                        state          <= S_WR;
                    end else begin
                        q_word <= load_val;
                        state  <= S_RESP;
                    end
                end
                S_WR: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= q_fault;
                    rsp_rdata <= (q_fault || q_write) ? 32'h0 : q_word;
`ifdef SRAM_LSU_STATS_EN
                    if (q_fault) begin
                        if (stat_faults != 16'hFFFF) begin
                            stat_faults <= stat_faults + 16'd1;
                        end
                    end else if (stat_accesses != 16'hFFFF) begin
                        stat_accesses <= stat_accesses + 16'd1;
                    end
`endif
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_lsu.sv
// tb_sram_lsu: scoreboard bench for sram_lsu with a 1-cycle SRAM model.
// Checks latency, data, faults, write traffic and mid-operation reset.
module tb_sram_lsu;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_read_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
`ifdef SRAM_LSU_STATS_EN
    logic [15:0] stat_accesses;
    logic [15:0] stat_faults;
`endif

    sram_lsu dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_address(req_address),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault),
        .mem_read_write(mem_read_write),
        .mem_address(mem_address),
        .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in)
`ifdef SRAM_LSU_STATS_EN
        ,
        .stat_accesses(stat_accesses),
        .stat_faults(stat_faults)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model: synchronous read, one edge of latency.
    logic [31:0] mem [0:24575];
    logic [31:0] rd_q;
    logic [14:0] idx;
    assign idx = (mem_address[16:2] < 15'd24576) ? mem_address[16:2] : 15'd0;
    assign mem_data_in = rd_q;

    always @(posedge clock) begin
        if (mem_read_write) mem[idx] <= mem_data_out;
        rd_q <= mem[idx];
    end

    int          cyc = 0;
    int          wr_count = 0;
    int          rsp_count = 0;
    logic [31:0] last_wa = 32'h0;
    logic [31:0] last_wd = 32'h0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_read_write) begin
            wr_count <= wr_count + 1;
            last_wa  <= mem_address;
            last_wd  <= mem_data_out;
        end
        if (rsp_valid) rsp_count <= rsp_count + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic do_req(input string nm, input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er,
                          input logic ef, input int el, input int ew,
                          input logic [31:0] ewd);
        int   acc;
        int   n0;
        bit   got;
        exp_t e;
        exp_t p;
        @(negedge clock);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready: got %b want 1", nm, req_ready);
        end
        req_valid   = 1'b1;
        req_write   = w;
        req_size    = sz;
        req_signed  = sg;
        req_address = a;
        req_wdata   = wd;
        n0 = wr_count;
        @(posedge clock);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        e.rdata = er;
        e.fault = ef;
        e.lat   = el;
        sb.push_back(e);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                got = 1;
                p = sb.pop_front();
                total++;
                if (rsp_rdata !== p.rdata) begin
                    bad++;
                    $display("FAIL %s rdata: got %h want %h", nm, rsp_rdata, p.rdata);
                end
                total++;
                if (rsp_fault !== p.fault) begin
                    bad++;
                    $display("FAIL %s fault: got %b want %b", nm, rsp_fault, p.fault);
                end
                total++;
                if (cyc - acc !== p.lat) begin
                    bad++;
                    $display("FAIL %s latency: got %0d want %0d", nm, cyc - acc, p.lat);
                end
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no rsp_valid within 20 cycles", nm);
            p = sb.pop_front();
        end
        total++;
        if (wr_count - n0 !== ew) begin
            bad++;
            $display("FAIL %s writes: got %0d want %0d", nm, wr_count - n0, ew);
        end
        if (ew == 1) begin
            total++;
            if (last_wa !== {a[31:2], 2'b00} || last_wd !== ewd) begin
                bad++;
                $display("FAIL %s wrword: got %h@%h want %h@%h",
                         nm, last_wd, last_wa, ewd, {a[31:2], 2'b00});
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0 ||
            rsp_rdata !== 32'h0 || mem_read_write !== 1'b0 ||
            mem_address !== 32'h0 || mem_data_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b v=%b f=%b d=%h rw=%b a=%h o=%h want 1 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_fault, rsp_rdata,
                     mem_read_write, mem_address, mem_data_out);
        end
`ifdef SRAM_LSU_STATS_EN
        total++;
        if (stat_accesses !== 16'h0 || stat_faults !== 16'h0) begin
            bad++;
            $display("FAIL reset_stats: got %h %h want 0 0", stat_accesses, stat_faults);
        end
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_word();
        do_req("st_w", 1, 2'b10, 0, 32'h2000_0000, 32'h0123_4567,
               32'h0, 0, 3, 1, 32'h0123_4567);
        do_req("ld_w", 0, 2'b10, 0, 32'h2000_0000, 32'h0,
               32'h0123_4567, 0, 4, 0, 32'h0);
    endtask

    task automatic test_rmw();
        do_req("st_b", 1, 2'b00, 0, 32'h2000_0001, 32'hFFFF_FFAB,
               32'h0, 0, 5, 1, 32'h0123_AB67);
        do_req("ld_w2", 0, 2'b10, 0, 32'h2000_0000, 32'h0,
               32'h0123_AB67, 0, 4, 0, 32'h0);
    endtask

    task automatic test_extend();
        do_req("ld_bs", 0, 2'b00, 1, 32'h2000_0001, 32'h0,
               32'hFFFF_FFAB, 0, 4, 0, 32'h0);
        do_req("ld_bu", 0, 2'b00, 0, 32'h2000_0001, 32'h0,
               32'h0000_00AB, 0, 4, 0, 32'h0);
        do_req("ld_hs2", 0, 2'b01, 1, 32'h2000_0002, 32'h0,
               32'h0000_0123, 0, 4, 0, 32'h0);
        do_req("ld_hs0", 0, 2'b01, 1, 32'h2000_0000, 32'h0,
               32'hFFFF_AB67, 0, 4, 0, 32'h0);
        do_req("ld_hu0", 0, 2'b01, 0, 32'h2000_0000, 32'h0,
               32'h0000_AB67, 0, 4, 0, 32'h0);
    endtask

    task automatic test_faults();
        do_req("f_end", 1, 2'b10, 0, 32'h2001_8000, 32'hDEAD_BEEF,
               32'h0, 1, 2, 0, 32'h0);
        do_req("f_low", 0, 2'b00, 0, 32'h1FFF_FFFF, 32'h0,
               32'h0, 1, 2, 0, 32'h0);
        do_req("f_mis", 0, 2'b01, 0, 32'h2000_0001, 32'h0,
               32'h0, 1, 2, 0, 32'h0);
        do_req("f_sz", 0, 2'b11, 0, 32'h2000_0000, 32'h0,
               32'h0, 1, 2, 0, 32'h0);
        do_req("f_wrap", 0, 2'b00, 0, 32'hFFFF_FFFF, 32'h0,
               32'h0, 1, 2, 0, 32'h0);
        do_req("f_hend", 1, 2'b01, 0, 32'h2001_7FFF, 32'h1234,
               32'h0, 1, 2, 0, 32'h0);
    endtask

    task automatic test_boundary();
        do_req("st_top", 1, 2'b10, 0, 32'h2001_7FFC, 32'h89AB_CDEF,
               32'h0, 0, 3, 1, 32'h89AB_CDEF);
        do_req("st_topb", 1, 2'b00, 0, 32'h2001_7FFF, 32'h0000_005A,
               32'h0, 0, 5, 1, 32'h5AAB_CDEF);
        do_req("ld_top", 0, 2'b10, 0, 32'h2001_7FFC, 32'h0,
               32'h5AAB_CDEF, 0, 4, 0, 32'h0);
        do_req("ld_topb", 0, 2'b00, 1, 32'h2001_7FFF, 32'h0,
               32'h0000_005A, 0, 4, 0, 32'h0);
    endtask

    task automatic test_half_store();
        do_req("st_h", 1, 2'b01, 0, 32'h2000_0002, 32'h0000_BEEF,
               32'h0, 0, 5, 1, 32'hBEEF_AB67);
        do_req("ld_w3", 0, 2'b10, 0, 32'h2000_0000, 32'h0,
               32'hBEEF_AB67, 0, 4, 0, 32'h0);
    endtask

    task automatic test_reset_mid_rmw();
        int n0;
        int r0;
        @(negedge clock);
        n0 = wr_count;
        r0 = rsp_count;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_address = 32'h2000_0000;
        req_wdata   = 32'h0000_0011;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (mem_read_write !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_now: got rw=%b rdy=%b want 0 1",
                     mem_read_write, req_ready);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clock);
        total++;
        if (wr_count !== n0) begin
            bad++;
            $display("FAIL rst_mid_wr: got %0d writes want 0", wr_count - n0);
        end
        total++;
        if (rsp_count !== r0) begin
            bad++;
            $display("FAIL rst_mid_rsp: got %0d responses want 0", rsp_count - r0);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_rdy: got %b want 1", req_ready);
        end
        do_req("ld_after", 0, 2'b10, 0, 32'h2000_0000, 32'h0,
               32'hBEEF_AB67, 0, 4, 0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 24576; i++) mem[i] = 32'h0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_address = 32'h0;
        req_wdata   = 32'h0;
        test_reset();
        test_word();
        test_rmw();
        test_extend();
        test_faults();
        test_boundary();
        test_half_store();
        test_reset_mid_rmw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
